// File: rtl/wf_iq_capture_pkg.sv
// Shared types for the waterfall I/Q capture buffer: mode codes, FSM states,
// default geometry and the mode-decode helper.
package wf_iq_capture_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_AW     = 13;

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'd0,
    MODE_CONTIN  = 2'd1,
    MODE_PRETRIG = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_RING = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // The reserved code behaves exactly like one-shot.
  function automatic mode_e decode_mode(input logic [1:0] code);
    case (code)
      2'd1:    return MODE_CONTIN;
      2'd2:    return MODE_PRETRIG;
      default: return MODE_ONESHOT;
    endcase
  endfunction

endpackage

// File: rtl/wf_iq_capture_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// Read returns the word held before a same-cycle write to that address.
module wf_iq_capture_ram #(
  parameter int WIDTH = 32,
  parameter int AW    = 13
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/wf_iq_capture.sv
// I/Q capture buffer: one-shot, continuous ring and pre-trigger capture of
// decimated sample pairs, with sequential oldest-first host readout.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | configured, waiting for arm; samples ignored
//   ST_FILL | one-shot: storing until the buffer is full
//   ST_RING | continuous / pre-trigger: storing, wrapping over oldest
//   ST_POST | pre-trigger: counting down post-trigger samples
//   ST_DONE | capture complete; samples blocked and flagged as overrun
module wf_iq_capture
  import wf_iq_capture_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int AW     = DEF_AW
) (
  input  logic              adc_clk,
  input  logic              reset_n,
  input  logic              cfg_load,
  input  logic [1:0]        cfg_mode,
  input  logic [AW-1:0]     cfg_post,
  input  logic              arm,
  input  logic              trig,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_i,
  input  logic [DATA_W-1:0] wr_q,
  input  logic              rd_sync,
  input  logic              rd_i,
  input  logic              rd_q,
  output logic [DATA_W-1:0] rd_data,
  output logic [AW:0]       wr_count,
  output logic              full,
  output logic              done,
  output logic              triggered,
  output logic              overrun
);

  localparam logic [AW:0] CNT_FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] CNT_LAST = {1'b0, {AW{1'b1}}};

  state_e              state;
  mode_e               mode;
  logic [AW-1:0]       post;
  logic [AW-1:0]       remain;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [2*DATA_W-1:0] ram_q;
  logic                capturing;
  logic                wr_en;

  assign capturing = (state == ST_FILL) || (state == ST_RING) || (state == ST_POST);
  assign wr_en     = wr && capturing && !cfg_load;
  assign full      = (wr_count == CNT_FULL);

  // cfg_post is AW bits wide, so it can never exceed DEPTH-1.
  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      mode      <= MODE_ONESHOT;
      post      <= '0;
      remain    <= '0;
      wr_ptr    <= '0;
      wr_count  <= '0;
      done      <= 1'b0;
      triggered <= 1'b0;
      overrun   <= 1'b0;
    end else if (cfg_load) begin
      state     <= ST_IDLE;
      mode      <= decode_mode(cfg_mode);
      post      <= cfg_post;
      remain    <= '0;
      wr_ptr    <= '0;
      wr_count  <= '0;
      done      <= 1'b0;
      triggered <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (wr_count != CNT_FULL) wr_count <= wr_count + 1'b1;
      end
      unique case (state)
        ST_IDLE: begin
          if (arm) state <= (mode == MODE_ONESHOT) ? ST_FILL : ST_RING;
        end
        ST_FILL: begin
          if (wr && wr_count == CNT_LAST) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_RING: begin
          // A sample arriving with the trigger is the last pre-trigger one.
          if (trig && mode == MODE_PRETRIG) begin
            triggered <= 1'b1;
            remain    <= post;
            if (post == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_POST;
            end
          end
        end
        ST_POST: begin
          if (wr) begin
            remain <= remain - 1'b1;
            if (remain == AW'(1)) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (wr) overrun <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr  <= '0;
      rd_data <= '0;
    end else if (rd_sync) begin
      rd_ptr <= full ? wr_ptr : '0;
    end else if (rd_q) begin
      rd_data <= ram_q[DATA_W-1:0];
      rd_ptr  <= rd_ptr + 1'b1;
    end else if (rd_i) begin
      rd_data <= ram_q[2*DATA_W-1:DATA_W];
    end
  end

  wf_iq_capture_ram #(
    .WIDTH (2*DATA_W),
    .AW    (AW)
  ) u_ram (
    .clk   (adc_clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata ({wr_i, wr_q}),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_wf_iq_capture.sv
// Bench for wf_iq_capture at AW=4: vector table, directed corner sequences and
// randomized capture runs against a sample-count based reference model.
module tb_wf_iq_capture;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          adc_clk = 1'b0;
  logic          reset_n;
  logic          cfg_load;
  logic [1:0]    cfg_mode;
  logic [AW-1:0] cfg_post;
  logic          arm, trig, wr;
  logic [DW-1:0] wr_i, wr_q;
  logic          rd_sync, rd_i, rd_q;
  logic [DW-1:0] rd_data;
  logic [AW:0]   wr_count;
  logic          full, done, triggered, overrun;

  always #5 adc_clk = ~adc_clk;

  wf_iq_capture #(.DATA_W(DW), .AW(AW)) dut (
    .adc_clk   (adc_clk),
    .reset_n   (reset_n),
    .cfg_load  (cfg_load),
    .cfg_mode  (cfg_mode),
    .cfg_post  (cfg_post),
    .arm       (arm),
    .trig      (trig),
    .wr        (wr),
    .wr_i      (wr_i),
    .wr_q      (wr_q),
    .rd_sync   (rd_sync),
    .rd_i      (rd_i),
    .rd_q      (rd_q),
    .rd_data   (rd_data),
    .wr_count  (wr_count),
    .full      (full),
    .done      (done),
    .triggered (triggered),
    .overrun   (overrun)
  );

  typedef struct {
    logic          cl;
    logic [1:0]    mode;
    logic [AW-1:0] post;
    logic          arm;
    logic          trig;
    logic          wr;
    logic [DW-1:0] wi;
    logic [DW-1:0] wq;
    logic          rs;
    logic          ri;
    logic          rq;
  } in_t;

  typedef struct {
    in_t           x;
    bit            chk_flags;
    int            cnt;
    bit            dn;
    bit            tg;
    bit            ov;
    bit            chk_rd;
    logic [DW-1:0] rd;
  } vec_t;

  typedef enum {P_IDLE, P_CAPT, P_POST, P_DONE} phase_e;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: buffer contents plus the number of samples accepted
  // since the last clear; occupancy and write slot follow from that count.
  logic [2*DW-1:0] m_mem [DEPTH];
  int              m_wseq, m_mode, m_post, m_left, m_rptr;
  phase_e          m_ph;
  bit              m_trg, m_ovr;
  logic [DW-1:0]   m_rd;

  function automatic in_t idle_in();
    in_t x;
    x.cl = 0; x.mode = '0; x.post = '0; x.arm = 0; x.trig = 0; x.wr = 0;
    x.wi = '0; x.wq = '0; x.rs = 0; x.ri = 0; x.rq = 0;
    return x;
  endfunction

  function automatic int m_cnt();
    return (m_wseq > DEPTH) ? DEPTH : m_wseq;
  endfunction

  task automatic drive(input in_t x);
    cfg_load = x.cl; cfg_mode = x.mode; cfg_post = x.post;
    arm = x.arm; trig = x.trig; wr = x.wr; wr_i = x.wi; wr_q = x.wq;
    rd_sync = x.rs; rd_i = x.ri; rd_q = x.rq;
  endtask

  task automatic model_reset();
    m_wseq = 0; m_mode = 0; m_post = 0; m_left = 0; m_rptr = 0;
    m_ph = P_IDLE; m_trg = 0; m_ovr = 0; m_rd = '0;
  endtask

  task automatic model_step(input in_t x);
    int wp_old;
    int cnt_old;
    bit store;
    wp_old  = m_wseq % DEPTH;
    cnt_old = m_cnt();
    if (x.rs) m_rptr = (cnt_old == DEPTH) ? wp_old : 0;
    else if (x.rq) begin
      m_rd   = m_mem[m_rptr][DW-1:0];
      m_rptr = (m_rptr + 1) % DEPTH;
    end else if (x.ri) m_rd = m_mem[m_rptr][2*DW-1:DW];
    if (x.cl) begin
      m_mode = (x.mode == 2'd1) ? 1 : ((x.mode == 2'd2) ? 2 : 0);
      m_post = int'(x.post);
      m_wseq = 0; m_left = 0; m_ph = P_IDLE; m_trg = 0; m_ovr = 0;
      return;
    end
    store = x.wr && (m_ph == P_CAPT || m_ph == P_POST);
    if (x.wr && m_ph == P_DONE) m_ovr = 1;
    if (store) begin
      m_mem[wp_old] = {x.wi, x.wq};
      m_wseq++;
    end
    case (m_ph)
      P_IDLE: if (x.arm) m_ph = P_CAPT;
      P_CAPT: begin
        if (m_mode == 0 && store && m_wseq == DEPTH) m_ph = P_DONE;
        else if (m_mode == 2 && x.trig) begin
          m_trg  = 1;
          m_left = m_post;
          m_ph   = (m_post == 0) ? P_DONE : P_POST;
        end
      end
      P_POST: if (x.wr) begin
        m_left--;
        if (m_left == 0) m_ph = P_DONE;
      end
      default: ;
    endcase
  endtask

  task automatic apply(input in_t x);
    drive(x);
    @(posedge adc_clk);
    #1;
    model_step(x);
    drive(idle_in());
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".cnt"},  32'(wr_count),  32'(m_cnt()));
    chk({tag, ".full"}, 32'(full),      32'(m_cnt() == DEPTH));
    chk({tag, ".done"}, 32'(done),      32'(m_ph == P_DONE));
    chk({tag, ".trig"}, 32'(triggered), 32'(m_trg));
    chk({tag, ".ovr"},  32'(overrun),   32'(m_ovr));
    chk({tag, ".rd"},   32'(rd_data),   32'(m_rd));
  endtask

  task automatic do_cfg(input int mode, input int post);
    in_t x = idle_in();
    x.cl = 1; x.mode = 2'(mode); x.post = AW'(post);
    apply(x);
  endtask

  task automatic do_arm();
    in_t x = idle_in();
    x.arm = 1;
    apply(x);
  endtask

  task automatic wr_one(input int iv, input int qv, input bit tg);
    in_t x = idle_in();
    x.wr = 1; x.wi = DW'(iv); x.wq = DW'(qv); x.trig = tg;
    apply(x);
  endtask

  task automatic rd_start();
    in_t x = idle_in();
    x.rs = 1;
    apply(x);
    apply(idle_in());
  endtask

  task automatic read_pair(output logic [DW-1:0] iv, output logic [DW-1:0] qv);
    in_t x = idle_in();
    x.ri = 1;
    apply(x);
    iv = rd_data;
    apply(idle_in());
    x = idle_in();
    x.rq = 1;
    apply(x);
    qv = rd_data;
    apply(idle_in());
  endtask

  task automatic chk_flags(input string tag, input int cnt, input bit dn, input bit tg, input bit ov);
    chk({tag, ".cnt"},  32'(wr_count),  32'(cnt));
    chk({tag, ".full"}, 32'(full),      32'(cnt == DEPTH));
    chk({tag, ".done"}, 32'(done),      32'(dn));
    chk({tag, ".trig"}, 32'(triggered), 32'(tg));
    chk({tag, ".ovr"},  32'(overrun),   32'(ov));
  endtask

  initial begin
    vec_t          tbl[$];
    vec_t          v;
    in_t           x;
    logic [DW-1:0] a, b;

    reset_n = 1'b0;
    drive(idle_in());
    model_reset();
    repeat (3) @(posedge adc_clk);
    #1;
    chk_flags("reset", 0, 0, 0, 0);
    chk("reset.rd", 32'(rd_data), 32'd0);
    reset_n = 1'b1;

    // ONESHOT vector table: 20 samples i=n q=-n, then full readout.
    v = '{x: idle_in(), chk_flags: 1, cnt: 0, dn: 0, tg: 0, ov: 0, chk_rd: 0, rd: '0};
    v.x.cl = 1; v.x.mode = 2'd0;
    tbl.push_back(v);
    v.x = idle_in(); v.x.arm = 1;
    tbl.push_back(v);
    for (int n = 0; n < 20; n++) begin
      v.x = idle_in(); v.x.wr = 1; v.x.wi = DW'(n); v.x.wq = DW'(-n);
      v.cnt = (n + 1 > DEPTH) ? DEPTH : n + 1;
      v.dn = (n >= 15); v.ov = (n >= 16);
      tbl.push_back(v);
    end
    v.x = idle_in(); v.x.rs = 1;
    tbl.push_back(v);
    v.x = idle_in();
    tbl.push_back(v);
    for (int n = 0; n < DEPTH; n++) begin
      v.x = idle_in(); v.x.ri = 1; v.chk_rd = 1; v.rd = DW'(n);
      tbl.push_back(v);
      v.x = idle_in(); v.chk_rd = 0;
      tbl.push_back(v);
      v.x = idle_in(); v.x.rq = 1; v.chk_rd = 1; v.rd = DW'(-n);
      tbl.push_back(v);
      v.x = idle_in(); v.chk_rd = 0;
      tbl.push_back(v);
    end
    foreach (tbl[k]) begin
      apply(tbl[k].x);
      if (tbl[k].chk_flags) chk_flags($sformatf("oneshot[%0d]", k), tbl[k].cnt, tbl[k].dn, tbl[k].tg, tbl[k].ov);
      if (tbl[k].chk_rd) chk($sformatf("oneshot_rd[%0d]", k), 32'(rd_data), 32'(tbl[k].rd));
    end

    // CONTIN: 37 samples, oldest-first readout wraps after 16 pairs.
    do_cfg(1, 0);
    do_arm();
    for (int n = 0; n < 37; n++) wr_one(n, n ^ 16'h5A5A, 0);
    chk_flags("contin", DEPTH, 0, 0, 0);
    rd_start();
    for (int k = 0; k < 17; k++) begin
      read_pair(a, b);
      chk($sformatf("contin_i[%0d]", k), 32'(a), 32'(21 + (k % DEPTH)));
      chk($sformatf("contin_q[%0d]", k), 32'(b), 32'((21 + (k % DEPTH)) ^ 16'h5A5A));
    end

    // PRETRIG post=5, trigger together with sample 10.
    do_cfg(2, 5);
    do_arm();
    for (int n = 0; n < 30; n++) begin
      wr_one(n, ~n, n == 10);
      chk_flags($sformatf("pretrig[%0d]", n), (n + 1 > DEPTH) ? DEPTH : n + 1, n >= 15, n >= 10, n >= 16);
    end
    rd_start();
    for (int k = 0; k < DEPTH; k++) begin
      read_pair(a, b);
      chk($sformatf("pretrig_i[%0d]", k), 32'(a), 32'(k));
    end

    // PRETRIG post=0: trigger ends capture immediately.
    do_cfg(2, 0);
    do_arm();
    for (int n = 0; n < 3; n++) wr_one(200 + n, 0, 0);
    wr_one(203, 0, 1);
    chk_flags("post0.trig", 4, 1, 1, 0);
    wr_one(204, 0, 0);
    chk_flags("post0.after", 4, 1, 1, 1);
    chk_model("post0.model");

    // cfg_load in POST with a sample in the same cycle.
    do_cfg(2, 5);
    do_arm();
    for (int n = 0; n < 3; n++) wr_one(100 + n, 0, 0);
    x = idle_in(); x.trig = 1;
    apply(x);
    wr_one(103, 0, 0);
    wr_one(104, 0, 0);
    chk("mid_post.trig_before", 32'(triggered), 32'd1);
    x = idle_in(); x.cl = 1; x.mode = 2'd2; x.post = AW'(5);
    x.wr = 1; x.wi = 16'h7777; x.wq = 16'h7777;
    apply(x);
    chk_flags("mid_post.clr", 0, 0, 0, 0);
    rd_start();
    for (int k = 0; k < 6; k++) begin
      read_pair(a, b);
      chk($sformatf("mid_post_i[%0d]", k), 32'(a), 32'((k < 5) ? 100 + k : 5));
    end
    chk_model("mid_post.model");

    // Asynchronous reset in FILL with read strobes and samples active.
    do_cfg(0, 0);
    do_arm();
    for (int n = 0; n < 5; n++) wr_one(n + 1, 0, 0);
    rd_start();
    x = idle_in(); x.ri = 1;
    apply(x);
    chk("rst.pre_rd", 32'(rd_data), 32'd1);
    apply(idle_in());
    x = idle_in(); x.wr = 1; x.wi = 16'h0F0F; x.ri = 1; x.rq = 1;
    drive(x);
    @(posedge adc_clk);
    #1;
    model_step(x);
    #2 reset_n = 1'b0;
    #1;
    chk_flags("rst.async", 0, 0, 0, 0);
    chk("rst.async_rd", 32'(rd_data), 32'd0);
    repeat (2) @(posedge adc_clk);
    #1;
    reset_n = 1'b1;
    drive(idle_in());
    model_reset();
    do_arm();
    wr_one(16'hABCD, 16'h1234, 0);
    chk("rst.restart_cnt", 32'(wr_count), 32'd1);
    rd_start();
    read_pair(a, b);
    chk("rst.restart_i", 32'(a), 32'hABCD);
    chk("rst.restart_q", 32'(b), 32'h1234);

    // Randomized capture runs against the model.
    for (int it = 0; it < 12; it++) begin
      do_cfg($urandom_range(0, 3), $urandom_range(0, DEPTH - 1));
      chk_model($sformatf("rnd%0d.cfg", it));
      do_arm();
      for (int c = 0; c < 40; c++) begin
        x = idle_in();
        x.wr   = 1'($urandom_range(0, 1));
        x.trig = ($urandom_range(0, 9) == 0);
        x.arm  = ($urandom_range(0, 15) == 0);
        x.wi   = DW'($urandom);
        x.wq   = DW'($urandom);
        apply(x);
        chk_model($sformatf("rnd%0d.c%0d", it, c));
      end
      rd_start();
      for (int k = 0; k < DEPTH; k++) begin
        x = idle_in(); x.ri = 1;
        apply(x);
        chk($sformatf("rnd%0d.ri%0d", it, k), 32'(rd_data), 32'(m_rd));
        apply(idle_in());
        x = idle_in(); x.rq = 1;
        apply(x);
        chk($sformatf("rnd%0d.rq%0d", it, k), 32'(rd_data), 32'(m_rd));
        apply(idle_in());
      end
      chk_model($sformatf("rnd%0d.end", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
